alu_wb_queue: RTL and testbench
===============================

Name: alu_wb_queue

Overview:
- Downstream stage of the combinational ALU. Captures each ALU result (alu_out, alu_overflow) plus its destination register tag into a small in-order FIFO, then presents it to the register-file write-back port under a valid/ready handshake.
- Decouples ALU issue from write-back stalls.
- Maintains a sticky overflow flag and a saturating overflow counter for the status/debug path.

Parameters:
- DATA_SIZE, 32, result width (matches ALU data width)
- RD_SIZE, 5, destination register index width
- DEPTH, 4, queue entries; power of two, >= 2
- CNT_SIZE, 8, overflow counter width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all control state
- in_valid  in  1  ALU stage presents a result this cycle
- in_ready  out  1  queue can accept; equals !full
- in_data  in  DATA_SIZE  ALU result (alu_out)
- in_ovf  in  1  ALU overflow flag (alu_overflow)
- in_ovf_chk  in  1  op is overflow-checked (signed ADD/SUB); otherwise in_ovf is ignored
- in_rd  in  RD_SIZE  destination register index
- wb_valid  out  1  head entry available
- wb_ready  in  1  write-back consumes head this cycle
- wb_data  out  DATA_SIZE  head result; 0 when empty
- wb_rd  out  RD_SIZE  head destination; 0 when empty
- wb_we  out  1  register write enable = wb_valid & (wb_rd != 0) & !wb_exc
- wb_exc  out  1  head entry overflowed (in_ovf & in_ovf_chk at push)
- ovf_clr  in  1  synchronous clear of sticky flag and counter
- ovf_sticky  out  1  any checked overflow since reset or last clear
- ovf_count  out  CNT_SIZE  number of checked overflows, saturating
- level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, any cycle, including mid-transfer):
  - wr_ptr, rd_ptr and level go to 0.
  - wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, wb_exc=0.
  - ovf_sticky=0, ovf_count=0, in_ready=1.
  - Storage array is not reset.
- Push = in_valid & in_ready. Writes {in_data, in_rd, in_ovf & in_ovf_chk} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop = wb_valid & wb_ready; rd_ptr increments modulo DEPTH.
- Latency: an entry pushed at edge N is visible on wb_* after edge N (first cycle it can pop is N+1). No combinational in->wb bypass.
- in_ready = (level != DEPTH), purely registered-state derived. No push while full, even with a simultaneous pop.
- wb_valid = (level != 0). wb_* are combinational from the head entry; wb_data and wb_rd are forced to 0 when empty.
- level update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - in_valid while full: ignored, nothing stored, in_ready stays 0
  - wb_ready while empty: ignored
- Order is strictly FIFO. Pointers wrap from DEPTH-1 to 0.
- Exception entries: wb_exc=1 forces wb_we=0, so the result is discarded. The entry still pops normally.
- rd=0 entries pop with wb_we=0.
- Overflow accounting, counted on push only (a refused in_valid never counts):
  - ovf_event = push & in_ovf & in_ovf_chk.
  - ovf_event: ovf_sticky <= 1; ovf_count increments, saturating at 2^CNT_SIZE-1.
  - ovf_clr without event: sticky <= 0, count <= 0.
  - ovf_clr with event in the same cycle: sticky <= 1, count <= 1 (event wins over clear).
- The queue never drops an accepted entry. Back-pressure only via in_ready.

Decomposition:
- Shared package alu_pkg:
  - DATA_SIZE, RD_SIZE constants (shared with ALU and register file).
  - Entry typedef wbq_entry_t {data, rd, exc}.
  - ALU op-code constants, so the issue stage derives in_ovf_chk from op in {ADD, SUB}.
- One sub-module, alu_wbq_mem: DEPTH x entry storage, one write port, one async read port at rd_ptr.
- Pointers, level, handshake and overflow counters stay in alu_wbq_queue top logic.

Test Plan:
- Reset with in_valid=1 held; release; push in_data=0x0000_0005, rd=3 at edge 1 -> wb_valid=1 after edge 1, wb_data=5, wb_rd=3, wb_we=1; wb_ready=1 pops, level returns to 0.
- Push 4 entries (data 1..4, rd 1..4) with wb_ready=0 -> level=4, in_ready=0; 5th in_valid ignored; drain with wb_ready=1 -> outputs 1,2,3,4 in order, then wb_data=0, wb_valid=0.
- Level=2, then simultaneous push and pop for 6 cycles -> level stays 2, pointer wrap verified, data order preserved.
- Push data=0x8000_0000, rd=5, ovf=1, chk=1 -> wb_exc=1, wb_we=0, ovf_sticky=1, ovf_count=1; push with ovf=1, chk=0 -> count unchanged; push rd=0 -> wb_we=0.
- 300 checked overflow pushes with continuous pops -> ovf_count saturates at 255; ovf_clr with a concurrent overflow push -> sticky=1, count=1; ovf_clr alone -> 0, 0.
- Async rst asserted mid-cycle with level=3 -> level=0, wb_valid=0, wb_data=0, ovf_* = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU / register-file definitions: data widths, op codes, write-back queue entry.
// The issue stage uses ovf_checked() to derive in_ovf_chk from the op code.
package alu_pkg;

  localparam int DATA_SIZE = 32;
  localparam int RD_SIZE   = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7
  } alu_op_t;

  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic [RD_SIZE-1:0]   rd;
    logic                 exc;
  } wbq_entry_t;

  // Only signed ADD/SUB report overflow as an exception.
  function automatic logic ovf_checked(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_wb_queue_if.sv
// ALU-result / register-file write-back bus with overflow status and occupancy.
// master = ALU issue + write-back side, slave = the queue.
interface alu_wb_queue_if #(
  parameter int DATA_SIZE = alu_pkg::DATA_SIZE,
  parameter int RD_SIZE   = alu_pkg::RD_SIZE,
  parameter int DEPTH     = 4,
  parameter int CNT_SIZE  = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_SIZE-1:0]       in_data;
  logic                       in_ovf;
  logic                       in_ovf_chk;
  logic [RD_SIZE-1:0]         in_rd;
  logic                       wb_valid;
  logic                       wb_ready;
  logic [DATA_SIZE-1:0]       wb_data;
  logic [RD_SIZE-1:0]         wb_rd;
  logic                       wb_we;
  logic                       wb_exc;
  logic                       ovf_clr;
  logic                       ovf_sticky;
  logic [CNT_SIZE-1:0]        ovf_count;
  logic [$clog2(DEPTH):0]     level;

  modport master (
    output in_valid, in_data, in_ovf, in_ovf_chk, in_rd, wb_ready, ovf_clr,
    input  in_ready, wb_valid, wb_data, wb_rd, wb_we, wb_exc, ovf_sticky, ovf_count, level
  );

  modport slave (
    input  in_valid, in_data, in_ovf, in_ovf_chk, in_rd, wb_ready, ovf_clr,
    output in_ready, wb_valid, wb_data, wb_rd, wb_we, wb_exc, ovf_sticky, ovf_count, level
  );
endinterface

// File: rtl/alu_wbq_mem.sv
// Write-back queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the queue pointers.
module alu_wbq_mem #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_wb_queue.sv
// In-order FIFO between the ALU and register-file write-back, with sticky/saturating overflow stats.
// Push visible on wb_* one edge later; back-pressure only through in_ready (= not full).
module alu_wb_queue
  import alu_pkg::*;
#(
  parameter int DATA_SIZE = alu_pkg::DATA_SIZE,
  parameter int RD_SIZE   = alu_pkg::RD_SIZE,
  parameter int DEPTH     = 4,
  parameter int CNT_SIZE  = 8
) (
  input logic           clk,
  input logic           rst,
  alu_wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic [RD_SIZE-1:0]   rd;
    logic                 exc;
  } entry_t;

  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic                full, not_empty, push, pop, ovf_event;
  logic                ovf_sticky;
  logic [CNT_SIZE-1:0] ovf_count;
  entry_t              wr_entry, head;

  assign full      = (level == LW'(DEPTH));
  assign not_empty = (level != '0);
  // A full queue refuses input even if the head pops this cycle.
  assign push      = bus.in_valid & ~full;
  assign pop       = not_empty & bus.wb_ready;

  assign wr_entry  = '{data: bus.in_data, rd: bus.in_rd, exc: bus.in_ovf & bus.in_ovf_chk};
  assign ovf_event = push & wr_entry.exc;

  alu_wbq_mem #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // An overflow in the same cycle as a clear leaves a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (bus.ovf_clr) begin
      ovf_sticky <= ovf_event;
      ovf_count  <= ovf_event ? CNT_SIZE'(1) : '0;
    end else if (ovf_event) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != {CNT_SIZE{1'b1}}) ovf_count <= ovf_count + 1'b1;
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.wb_valid   = not_empty;
  assign bus.wb_data    = not_empty ? head.data : '0;
  assign bus.wb_rd      = not_empty ? head.rd : '0;
  assign bus.wb_exc     = not_empty & head.exc;
  assign bus.wb_we      = not_empty & (bus.wb_rd != '0) & ~bus.wb_exc;
  assign bus.ovf_sticky = ovf_sticky;
  assign bus.ovf_count  = ovf_count;
  assign bus.level      = level;

endmodule

// File: tb/tb_alu_wb_queue.sv
// Scoreboard bench for alu_wb_queue: expected entries queued on accepted pushes, compared on pops.
module tb_alu_wb_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_wb_queue_if bus ();
  alu_wb_queue dut (.clk(clk), .rst(rst), .bus(bus));

  int         n_cmp = 0;
  int         n_bad = 0;
  wbq_entry_t sb[$];
  logic       m_sticky = 1'b0;
  int         m_count  = 0;
  logic       m_pop    = 1'b0;
  wbq_entry_t exp_e, got_e;

  // Drives one cycle of inputs and advances the reference model for the coming edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input alu_op_t op, input logic ovf, input logic rdy, input logic clr);
    logic acc, ev;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_rd      = rd;
    bus.in_ovf     = ovf;
    bus.in_ovf_chk = ovf_checked(op);
    bus.wb_ready   = rdy;
    bus.ovf_clr    = clr;
    m_pop = rdy && (sb.size() != 0);
    acc   = v && (sb.size() < DEPTH);
    ev    = acc && ovf && ovf_checked(op);
    if (acc) sb.push_back('{data: d, rd: rd, exc: ovf & ovf_checked(op)});
    if (clr) begin
      m_sticky = ev;
      m_count  = ev ? 1 : 0;
    end else if (ev) begin
      m_sticky = 1'b1;
      if (m_count < 255) m_count++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'd5; bus.in_rd = 5'd3; bus.in_ovf = 1'b1;
    bus.in_ovf_chk = 1'b1; bus.wb_ready = 1'b0; bus.ovf_clr = 1'b0;
    step(); step();
    n_cmp++;
    if ({bus.in_ready, bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_data, bus.wb_rd, bus.level,
         bus.ovf_sticky, bus.ovf_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b vld=%b we=%b exc=%b data=%h rd=%0d lvl=%0d stk=%b cnt=%0d want rdy=1 rest 0",
               bus.in_ready, bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_data, bus.wb_rd, bus.level,
               bus.ovf_sticky, bus.ovf_count);
    end
    rst = 1'b0;
    drive(1'b1, 32'h0000_0005, 5'd3, OP_AND, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_we, bus.level} !== {1'b1, 32'd5, 5'd3, 1'b1, 3'd1}) begin
      n_bad++;
      $display("FAIL first_push: vld=%b data=%h rd=%0d we=%b lvl=%0d want 1/5/3/1/1",
               bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_we, bus.level);
    end
    drive(1'b0, 32'd0, 5'd0, OP_AND, 1'b0, 1'b1, 1'b0);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL first_pop: got %h want %h", got_e, exp_e); end
    end
    step();
    n_cmp++;
    if ({bus.level, bus.wb_valid} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL first_drain: lvl=%0d vld=%b want 0/0", bus.level, bus.wb_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 5'(i), OP_OR, 1'b0, 1'b0, 1'b0);
      step();
    end
    n_cmp++;
    if ({bus.level, bus.in_ready} !== {3'd4, 1'b0}) begin
      n_bad++; $display("FAIL full_level: lvl=%0d in_ready=%b want 4/0", bus.level, bus.in_ready);
    end
    // Refused push carrying a checked overflow must neither store nor count.
    drive(1'b1, 32'd99, 5'd9, OP_ADD, 1'b1, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({bus.level, bus.in_ready, bus.wb_data, bus.ovf_sticky, bus.ovf_count} !== {3'd4, 1'b0, 32'd1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL full_refuse: lvl=%0d rdy=%b head=%h stk=%b cnt=%0d want 4/0/1/0/0",
               bus.level, bus.in_ready, bus.wb_data, bus.ovf_sticky, bus.ovf_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 5'd0, OP_OR, 1'b0, 1'b1, 1'b0);
      if (m_pop) begin
        exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
        n_cmp++;
        if (got_e !== exp_e || bus.wb_we !== 1'b1) begin
          n_bad++; $display("FAIL full_drain%0d: got %h we=%b want %h we=1", i, got_e, bus.wb_we, exp_e);
        end
      end
      step();
    end
    step();
    n_cmp++;
    if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.level} !== {1'b0, 32'd0, 5'd0, 3'd0}) begin
      n_bad++; $display("FAIL empty_outputs: vld=%b data=%h rd=%0d lvl=%0d want 0/0/0/0",
                        bus.wb_valid, bus.wb_data, bus.wb_rd, bus.level);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 5'(10 + i), OP_XOR, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 5'(20 + i), OP_XOR, 1'b0, 1'b1, 1'b0);
      if (m_pop) begin
        exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
        n_cmp++;
        if (got_e !== exp_e) begin n_bad++; $display("FAIL b2b_pop%0d: got %h want %h", i, got_e, exp_e); end
      end
      step();
      n_cmp++;
      if (bus.level !== 3'd2) begin n_bad++; $display("FAIL b2b_level%0d: got %0d want 2", i, bus.level); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'd0, 5'd0, OP_XOR, 1'b0, 1'b1, 1'b0);
      if (m_pop) begin
        exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
        n_cmp++;
        if (got_e !== exp_e) begin n_bad++; $display("FAIL b2b_drain%0d: got %h want %h", i, got_e, exp_e); end
      end
      step();
    end
  endtask

  task automatic test_exception();
    drive(1'b1, 32'h8000_0000, 5'd5, OP_ADD, 1'b1, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({bus.wb_exc, bus.wb_we, bus.ovf_sticky, bus.ovf_count} !== {1'b1, 1'b0, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL exc_entry: exc=%b we=%b stk=%b cnt=%0d want 1/0/1/1",
                        bus.wb_exc, bus.wb_we, bus.ovf_sticky, bus.ovf_count);
    end
    drive(1'b1, 32'd7, 5'd6, OP_SLT, 1'b1, 1'b1, 1'b0);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL exc_pop: got %h want %h", got_e, exp_e); end
    end
    step();
    n_cmp++;
    if ({bus.wb_exc, bus.wb_we, bus.ovf_count} !== {1'b0, 1'b1, 8'(m_count)}) begin
      n_bad++; $display("FAIL unchecked_ovf: exc=%b we=%b cnt=%0d want 0/1/%0d",
                        bus.wb_exc, bus.wb_we, bus.ovf_count, m_count);
    end
    drive(1'b1, 32'd9, 5'd0, OP_SUB, 1'b0, 1'b1, 1'b0);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL unchk_pop: got %h want %h", got_e, exp_e); end
    end
    step();
    n_cmp++;
    if ({bus.wb_valid, bus.wb_data, bus.wb_we} !== {1'b1, 32'd9, 1'b0}) begin
      n_bad++; $display("FAIL rd0_we: vld=%b data=%h we=%b want 1/9/0", bus.wb_valid, bus.wb_data, bus.wb_we);
    end
    drive(1'b0, 32'd0, 5'd0, OP_SUB, 1'b0, 1'b1, 1'b0);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL rd0_pop: got %h want %h", got_e, exp_e); end
    end
    step();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 5'(i % 31 + 1), (i % 2 == 0) ? OP_ADD : OP_SUB, 1'b1, 1'b1, 1'b0);
      if (m_pop) begin
        exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
        n_cmp++;
        if (got_e !== exp_e) begin n_bad++; $display("FAIL sat_pop%0d: got %h want %h", i, got_e, exp_e); end
      end
      step();
    end
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count} !== {1'b1, 8'd255}) begin
      n_bad++; $display("FAIL sat_count: stk=%b cnt=%0d want 1/255", bus.ovf_sticky, bus.ovf_count);
    end
    drive(1'b1, 32'h7FFF_FFFF, 5'd4, OP_ADD, 1'b1, 1'b1, 1'b1);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL clr_ev_pop: got %h want %h", got_e, exp_e); end
    end
    step();
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count} !== {m_sticky, 8'(m_count)} || m_count != 1) begin
      n_bad++; $display("FAIL clr_with_event: stk=%b cnt=%0d want 1/1", bus.ovf_sticky, bus.ovf_count);
    end
    drive(1'b0, 32'd0, 5'd0, OP_ADD, 1'b0, 1'b1, 1'b1);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL clr_pop: got %h want %h", got_e, exp_e); end
    end
    step();
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count, bus.level} !== {1'b0, 8'd0, 3'd0}) begin
      n_bad++; $display("FAIL clr_alone: stk=%b cnt=%0d lvl=%0d want 0/0/0", bus.ovf_sticky, bus.ovf_count, bus.level);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 5'(i + 1), OP_ADD, (i == 1), 1'b0, 1'b0);
      step();
    end
    n_cmp++;
    if ({bus.level, bus.ovf_count} !== {3'd3, 8'd1}) begin
      n_bad++; $display("FAIL pre_rst: lvl=%0d cnt=%0d want 3/1", bus.level, bus.ovf_count);
    end
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.level, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.in_ready, bus.ovf_sticky, bus.ovf_count}
        !== {3'd0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 8'd0}) begin
      n_bad++; $display("FAIL async_rst: lvl=%0d vld=%b data=%h rd=%0d rdy=%b stk=%b cnt=%0d want 0/0/0/0/1/0/0",
                        bus.level, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.in_ready, bus.ovf_sticky, bus.ovf_count);
    end
    sb.delete();
    m_sticky = 1'b0;
    m_count  = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    drive(1'b1, 32'h55, 5'd17, OP_AND, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 5'd0, OP_AND, 1'b0, 1'b1, 1'b0);
    if (m_pop) begin
      exp_e = sb.pop_front(); got_e = '{bus.wb_data, bus.wb_rd, bus.wb_exc};
      n_cmp++;
      if (got_e !== exp_e) begin n_bad++; $display("FAIL post_rst_pop: got %h want %h", got_e, exp_e); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_back_to_back();
    test_exception();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
